press_gen: RTL and testbench



---
 rtl/press_pkg.sv | 18 +
 rtl/press_queue.sv | 52 +++++
 rtl/press_gen.sv | 116 +++++++++++
 tb/tb_press_gen.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/press_pkg.sv
// press_pkg: shared types and constants for the press generator.
//   press_state_t  - FSM states (IDLE, HIGH, LOW)
//   HIGH_TICKS_DEF - default number of slow ticks the press is held high
//   LOW_TICKS_DEF  - default minimum number of slow ticks held low between presses
//   TICK_CNT_W     - width of the slow-tick counter
package press_pkg;

    localparam int unsigned TICK_CNT_W     = 8;
    localparam int unsigned HIGH_TICKS_DEF = 2;
    localparam int unsigned LOW_TICKS_DEF  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } press_state_t;

endpackage

// File: rtl/press_queue.sv
// press_queue: saturating up/down counter of queued press requests.
//   clk, rst_n  - clock and synchronous active-low reset
//   inc_i       - a request arrived this cycle
//   dec_i       - a press starts this cycle (consumes one request)
//   count_o     - requests currently queued
//   full_o      - count_o is at its maximum (all ones)
//   overflow_o  - sticky: an increment was dropped while full
module press_queue #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc_i,
    input  logic         dec_i,
    output logic [W-1:0] count_o,
    output logic         full_o,
    output logic         overflow_o
);

    logic [W-1:0] count_q, count_d;
    logic         ovf_q, ovf_d;

    assign full_o     = &count_q;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;

    // inc and dec together cancel; a lone inc at saturation is dropped and flagged
    always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (inc_i && !dec_i) begin
            if (full_o) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + W'(1);
            end
        end else if (dec_i && !inc_i) begin
            count_d = count_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: rtl/press_gen.sv
// press_gen: turns single-cycle req strobes into tick-aligned press waveforms
// (high for HIGH_TICKS slow ticks, then low for at least LOW_TICKS slow ticks).
//   clk        - system clock
//   rst_n      - synchronous reset, active low
//   slow_tick  - one-cycle enable marking each slow sampling instant
//   req        - one-cycle strobe requesting one press
//   out        - generated press level (registered)
//   busy       - a press is in progress or requests are queued
//   pending    - queued requests not yet started
//   overflow   - sticky: a request was dropped at saturation
//   done       - (only with PRESS_GEN_DONE_EN) one-cycle pulse on LOW->IDLE
// Optional feature macro: PRESS_GEN_DONE_EN
module press_gen
    import press_pkg::*;
#(
    parameter int unsigned HIGH_TICKS = HIGH_TICKS_DEF,
    parameter int unsigned LOW_TICKS  = LOW_TICKS_DEF,
    parameter int unsigned PEND_W     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              slow_tick,
    input  logic              req,
    output logic              out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow
`ifdef PRESS_GEN_DONE_EN
    ,
    output logic              done
`endif
);

    localparam logic [TICK_CNT_W-1:0] HIGH_LAST = TICK_CNT_W'(HIGH_TICKS - 1);
    localparam logic [TICK_CNT_W-1:0] LOW_LAST  = TICK_CNT_W'(LOW_TICKS - 1);

    press_state_t          state_q;
    logic [TICK_CNT_W-1:0] cnt_q;
    logic                  out_q;
    logic                  start_c;
    logic                  q_full;

    // A press starts on a tick in IDLE when a request is queued or arriving now
    assign start_c = (state_q == IDLE) && slow_tick && ((pending != '0) || req);

    press_queue #(
        .W (PEND_W)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (req),
        .dec_i      (start_c),
        .count_o    (pending),
        .full_o     (q_full),
        .overflow_o (overflow)
    );

    // A full queue is also non-empty; folding it in keeps the term explicit
    assign busy = (state_q != IDLE) || (pending != '0) || q_full;
    assign out  = out_q;

`ifdef PRESS_GEN_DONE_EN
    logic done_q;
    assign done = done_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            done_q <= 1'b0;
        end else begin
            done_q <= slow_tick && (state_q == LOW) && (cnt_q == LOW_LAST);
        end
    end
`endif

    // Press FSM: state, tick count and level only move on slow_tick
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= 1'b0;
        end else if (slow_tick) begin
            case (state_q)
                IDLE: begin
                    if (start_c) begin
                        state_q <= HIGH;
                        out_q   <= 1'b1;
                        cnt_q   <= '0;
                    end
                end
                HIGH: begin
                    if (cnt_q == HIGH_LAST) begin
                        state_q <= LOW;
                        out_q   <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + TICK_CNT_W'(1);
                    end
                end
                LOW: begin
                    if (cnt_q == LOW_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + TICK_CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    out_q   <= 1'b0;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_press_gen.sv
// tb_press_gen: two press_gen instances (defaults, and H=1/L=3/PEND_W=2) share
// one stimulus stream; a tick-count model predicts every output each cycle.
module tb_press_gen;

    logic       clk;
    logic       rst_n;
    logic       slow_tick;
    logic       req;

    logic       out0, busy0, ovf0;
    logic [3:0] pend0;
    logic       out1, busy1, ovf1;
    logic [1:0] pend1;
`ifdef PRESS_GEN_DONE_EN
    logic       done0, done1;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    press_gen u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .slow_tick (slow_tick),
        .req       (req),
        .out       (out0),
        .busy      (busy0),
        .pending   (pend0),
        .overflow  (ovf0)
`ifdef PRESS_GEN_DONE_EN
        ,
        .done      (done0)
`endif
    );

    press_gen #(
        .HIGH_TICKS (1),
        .LOW_TICKS  (3),
        .PEND_W     (2)
    ) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .slow_tick (slow_tick),
        .req       (req),
        .out       (out1),
        .busy      (busy1),
        .pending   (pend1),
        .overflow  (ovf1)
`ifdef PRESS_GEN_DONE_EN
        ,
        .done      (done1)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model: a press is "active" for HIGH+LOW ticks after its start tick;
    // out is high while fewer than HIGH ticks have elapsed since the start.
    int m_h[2]   = '{2, 1};
    int m_l[2]   = '{2, 3};
    int m_max[2] = '{15, 3};
    bit m_act[2];
    int m_ph[2];
    int m_pend[2];
    bit m_ovf[2];
    bit m_done[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0; m_ph[i] = 0; m_pend[i] = 0; m_ovf[i] = 0; m_done[i] = 0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_act[i] = 0; m_ph[i] = 0; m_pend[i] = 0; m_ovf[i] = 0; m_done[i] = 0;
            end else begin
                bit st;
                st = !m_act[i] && slow_tick && (m_pend[i] != 0 || req);
                m_done[i] = 0;
                if (m_act[i] && slow_tick) begin
                    m_ph[i]++;
                    if (m_ph[i] == m_h[i] + m_l[i]) begin
                        m_act[i]  = 0;
                        m_done[i] = 1;
                    end
                end
                if (st) begin
                    m_act[i] = 1;
                    m_ph[i]  = 0;
                end
                if (req && !st) begin
                    if (m_pend[i] == m_max[i]) m_ovf[i] = 1;
                    else m_pend[i]++;
                end else if (st && !req) begin
                    m_pend[i]--;
                end
            end
        end
    end

    function automatic int m_out(input int i);
        return (m_act[i] && m_ph[i] < m_h[i]) ? 1 : 0;
    endfunction

    function automatic int m_busy(input int i);
        return (m_act[i] || m_pend[i] != 0) ? 1 : 0;
    endfunction

    task automatic cmp(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (chk_en) begin
            cmp("out0", int'(out0), m_out(0));
            cmp("busy0", int'(busy0), m_busy(0));
            cmp("pend0", int'(pend0), m_pend[0]);
            cmp("ovf0", int'(ovf0), int'(m_ovf[0]));
            cmp("out1", int'(out1), m_out(1));
            cmp("busy1", int'(busy1), m_busy(1));
            cmp("pend1", int'(pend1), m_pend[1]);
            cmp("ovf1", int'(ovf1), int'(m_ovf[1]));
`ifdef PRESS_GEN_DONE_EN
            cmp("done0", int'(done0), int'(m_done[0]));
            cmp("done1", int'(done1), int'(m_done[1]));
`endif
        end
    end

    // Downstream two-FF tick-sampled edge detector on out0
    logic ed1 = 1'b0, ed2 = 1'b0;
    int   ed_cnt = 0;
    always @(posedge clk) begin
        if (slow_tick) begin
            if (ed1 && !ed2) ed_cnt <= ed_cnt + 1;
            ed1 <= out0;
            ed2 <= ed1;
        end
    end

    task automatic drive(input logic r, input logic t, input logic q);
        @(negedge clk);
        #1;
        rst_n = r; slow_tick = t; req = q;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int hi0, hi1, first_hi, rises, prev, ed0, dn;
        rst_n = 1'b0; slow_tick = 1'b0; req = 1'b0;

        // single request, tick every 4 clk
        do_reset();
        chk_en = 1;
        drive(1'b1, 1'b0, 1'b1);
        cmp("rst_out", int'(out0), 0);
        cmp("rst_busy", int'(busy0), 0);
        cmp("rst_pend", int'(pend0), 0);
        hi0 = 0; hi1 = 0; first_hi = -1;
        for (int k = 0; k < 24; k++) begin
            drive(1'b1, 1'(k % 4 == 3), 1'b0);
            if (k == 0) cmp("single_pend", int'(pend0), 1);
            if (out0) begin
                hi0++;
                if (first_hi < 0) first_hi = k;
            end
            if (out1) hi1++;
            if (k == 19) cmp("single_busy_last", int'(busy0), 1);
            if (k == 20) cmp("single_busy_clear", int'(busy0), 0);
        end
        cmp("single_first_hi", first_hi, 4);
        cmp("single_hi_cycles0", hi0, 8);
        cmp("single_hi_cycles1", hi1, 4);

        // three back-to-back requests, third coincides with the start tick
        do_reset();
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        cmp("b2b_pend1", int'(pend0), 1);
        drive(1'b1, 1'b1, 1'b1);
        cmp("b2b_pend2", int'(pend0), 2);
        ed0 = ed_cnt; rises = 0; prev = 0; dn = 0;
        for (int k = 0; k < 100; k++) begin
            drive(1'b1, 1'(k % 4 == 3), 1'b0);
            if (k == 0) begin
                cmp("b2b_pend_start", int'(pend0), 2);
                cmp("b2b_out_start", int'(out0), 1);
            end
            if (out0 && prev == 0) rises++;
            prev = int'(out0);
`ifdef PRESS_GEN_DONE_EN
            if (done0) dn++;
`endif
        end
        cmp("b2b_presses", rises, 3);
        cmp("b2b_edge_pulses", ed_cnt - ed0, 3);
`ifdef PRESS_GEN_DONE_EN
        cmp("b2b_done_pulses", dn, 3);
`endif

        // saturation: five requests without a tick
        do_reset();
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 1'b1);
            if (k == 3) begin
                cmp("sat_pend1_3", int'(pend1), 3);
                cmp("sat_ovf1_pre", int'(ovf1), 0);
            end
            if (k == 4) cmp("sat_ovf1_4th", int'(ovf1), 1);
        end
        drive(1'b1, 1'b0, 1'b0);
        cmp("sat_pend1", int'(pend1), 3);
        cmp("sat_ovf1", int'(ovf1), 1);
        cmp("sat_pend0", int'(pend0), 5);
        cmp("sat_ovf0", int'(ovf0), 0);
        for (int k = 0; k < 120; k++) drive(1'b1, 1'(k % 4 == 3), 1'b0);
        cmp("sat_ovf1_sticky", int'(ovf1), 1);

        // request coincident with start while one is queued
        do_reset();
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        cmp("coin_pend_pre", int'(pend0), 1);
        drive(1'b1, 1'b0, 1'b0);
        cmp("coin_pend", int'(pend0), 1);
        cmp("coin_out", int'(out0), 1);
        rises = 1; prev = 1;
        for (int k = 0; k < 60; k++) begin
            drive(1'b1, 1'(k % 4 == 3), 1'b0);
            if (out0 && prev == 0) rises++;
            prev = int'(out0);
        end
        cmp("coin_presses", rises, 2);

        // reset during HIGH with two queued
        do_reset();
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        cmp("mid_pend", int'(pend0), 2);
        cmp("mid_out", int'(out0), 1);
        drive(1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        cmp("mid_rst_out", int'(out0), 0);
        cmp("mid_rst_pend", int'(pend0), 0);
        cmp("mid_rst_busy", int'(busy0), 0);
        rises = 0; prev = 0;
        for (int k = 0; k < 40; k++) begin
            drive(1'b1, 1'(k % 4 == 3), 1'b0);
            if (out0 && prev == 0) rises++;
            prev = int'(out0);
        end
        cmp("mid_no_press", rises, 0);

        // randomized: sparse then dense requests, rare resets
        for (int k = 0; k < 4000; k++) begin
            logic r, t, q;
            r = ($urandom_range(0, 399) != 0);
            t = ($urandom_range(0, 2) == 0);
            q = (k < 2000) ? ($urandom_range(0, 15) == 0) : ($urandom_range(0, 2) == 0);
            drive(r, t, q);
        end

        drive(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
